// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: log2 sizing and per-level element counts.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package adder_tree_pkg;

    // Defaults used by the top module parameter list.
    localparam int DEF_IN_BW  = 16;
    localparam int DEF_OUT_BW = 24;
    localparam int DEF_NUM_IN = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of elements entering level k of a tree fed with n inputs.
    // Each level halves the count, rounding up for the odd pass-through element.
    function automatic int level_width(input int n, input int k);
        int w;
        w = n;
        for (int i = 0; i < k; i++) begin
            w = (w + 1) / 2;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One reduction level: pairs neighbouring elements, odd last element passes through, then registers.
// Latency: 1 cycle (register after the adders).
// Backpressure: register holds while en_i=0; valid/last/data advance together when en_i=1.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   en_i           stage advance enable (deasserted during downstream stall)
//   vld_i, last_i  beat valid / group-last entering this level
//   dat_i          N_IN signed elements of W bits, element i at [i*W +: W]
//   vld_o, last_o  registered valid / last
//   dat_o          ceil(N_IN/2) registered sums
module adder_tree_stage
    import adder_tree_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int W    = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en_i,
    input  logic                          vld_i,
    input  logic                          last_i,
    input  logic [N_IN*W-1:0]             dat_i,
    output logic                          vld_o,
    output logic                          last_o,
    output logic [((N_IN+1)/2)*W-1:0]     dat_o
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*W-1:0] sum_d;
    logic [N_OUT*W-1:0] dat_q;
    logic               vld_q;
    logic               last_q;

    genvar j;
    for (j = 0; j < N_OUT; j++) begin : g_pair
        if (2 * j + 1 < N_IN) begin : g_add
            // Width is already wide enough for the full tree, so this add is exact.
            assign sum_d[j*W +: W] = dat_i[(2*j)*W +: W] + dat_i[(2*j+1)*W +: W];
        end else begin : g_pass
            assign sum_d[j*W +: W] = dat_i[(2*j)*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            dat_q  <= '0;
        end else if (en_i) begin
            vld_q  <= vld_i;
            // last is only meaningful alongside a valid beat
            last_q <= vld_i & last_i;
            dat_q  <= sum_d;
        end
    end

    assign vld_o  = vld_q;
    assign last_o = last_q;
    assign dat_o  = dat_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed reduction tree with multi-beat group accumulation and wrap/saturate overflow.
// Latency: single-beat group accepted at cycle t -> out_valid at t+clog2(NUM_IN)+1.
// Backpressure: out_valid & ~out_ready freezes every stage, the accumulator and outputs; in_ready=0.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_last  input beat handshake, in_last closes the accumulation group
//   data_in_flat               NUM_IN signed IN_BW elements, element i at [i*IN_BW +: IN_BW]
//   out_valid/out_ready        group result handshake
//   out_sum, out_ovf           signed group sum and sticky group overflow flag
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int IN_BW  = DEF_IN_BW,
    parameter int OUT_BW = DEF_OUT_BW,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [IN_BW*NUM_IN-1:0] data_in_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_BW-1:0]       out_sum,
    output logic                    out_ovf
);

    localparam int LEVELS = clog2(NUM_IN);
    localparam int MSB    = OUT_BW - 1;
    localparam logic [OUT_BW-1:0] SMAX = {1'b0, {(OUT_BW-1){1'b1}}};
    localparam logic [OUT_BW-1:0] SMIN = {1'b1, {(OUT_BW-1){1'b0}}};

    logic stall;
    logic stage_en;

    logic [NUM_IN*OUT_BW-1:0] ext;

    logic              tree_vld;
    logic              tree_last;
    logic [OUT_BW-1:0] tree_sum;

    logic [OUT_BW-1:0] acc_q, acc_d;
    logic              first_q, first_d;
    logic              grp_ovf_q, grp_ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_BW-1:0] out_sum_q, out_sum_d;
    logic              out_ovf_q, out_ovf_d;

    logic [OUT_BW-1:0] acc_base;
    logic [OUT_BW-1:0] raw_sum;
    logic [OUT_BW-1:0] acc_res;
    logic              add_ovf;
    logic              grp_ovf;

    assign stall    = out_valid_q & ~out_ready;
    assign stage_en = ~stall;
    // Held low during reset so no beat is considered accepted while the pipe is being flushed.
    assign in_ready = rst_n & ~stall;

    // Sign-extend every element to the full tree width up front.
    genvar i;
    for (i = 0; i < NUM_IN; i++) begin : g_ext
        assign ext[i*OUT_BW +: OUT_BW] = OUT_BW'($signed(data_in_flat[i*IN_BW +: IN_BW]));
    end

    genvar k;
    for (k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI = level_width(NUM_IN, k);
        localparam int NO = level_width(NUM_IN, k + 1);

        logic [NI*OUT_BW-1:0] din;
        logic                 vin;
        logic                 lin;
        logic [NO*OUT_BW-1:0] dout;
        logic                 vout;
        logic                 lout;

        if (k == 0) begin : g_head
            assign din = ext;
            assign vin = in_valid;
            assign lin = in_last;
        end else begin : g_body
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
            assign lin = g_lvl[k-1].lout;
        end

        adder_tree_stage #(
            .N_IN (NI),
            .W    (OUT_BW)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (stage_en),
            .vld_i  (vin),
            .last_i (lin),
            .dat_i  (din),
            .vld_o  (vout),
            .last_o (lout),
            .dat_o  (dout)
        );
    end

    assign tree_vld  = g_lvl[LEVELS-1].vout;
    assign tree_last = g_lvl[LEVELS-1].lout;
    assign tree_sum  = g_lvl[LEVELS-1].dout;

    // Accumulator datapath: the first beat of a group starts from zero.
    always_comb begin
        acc_base = first_q ? '0 : acc_q;
        raw_sum  = acc_base + tree_sum;
        // Two same-sign operands giving an opposite-sign result is a signed overflow.
        add_ovf  = (acc_base[MSB] == tree_sum[MSB]) && (raw_sum[MSB] != acc_base[MSB]);
        acc_res  = raw_sum;
        if ((SAT != 0) && add_ovf) begin
            acc_res = tree_sum[MSB] ? SMIN : SMAX;
        end
        grp_ovf  = (first_q ? 1'b0 : grp_ovf_q) | add_ovf;
    end

    always_comb begin
        acc_d       = acc_q;
        first_d     = first_q;
        grp_ovf_d   = grp_ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        if (!stall) begin
            // Not stalled means either no result was pending or it is being taken now.
            out_valid_d = 1'b0;
            if (tree_vld) begin
                acc_d     = acc_res;
                first_d   = tree_last;
                grp_ovf_d = grp_ovf;
                if (tree_last) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = acc_res;
                    out_ovf_d   = grp_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            grp_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            first_q     <= first_d;
            grp_ovf_q   <= grp_ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe across four parameter sets.
// Latency: checks first-result latency directly; results checked by a decoupled monitor.
// Backpressure: exercises out_ready stalls and back-to-back groups.
module tb_adder_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv   [4];
    logic       il   [4];
    logic       ordy [4];
    logic       irdy [4];
    logic       ov   [4];
    logic       oo   [4];
    logic [255:0] din [4];
    logic [23:0] os0, os1;
    logic [19:0] os2, os3;
    int         act  [4];

    assign act[0] = int'($signed(os0));
    assign act[1] = int'($signed(os1));
    assign act[2] = int'($signed(os2));
    assign act[3] = int'($signed(os3));

    // d=0: 16 inputs, 24-bit wrap
    adder_tree_pipe #(.IN_BW(16), .OUT_BW(24), .NUM_IN(16), .SAT(0)) u_n16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .in_last(il[0]),
        .data_in_flat(din[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(os0), .out_ovf(oo[0]));
    // d=1: 5 inputs (odd tree)
    adder_tree_pipe #(.IN_BW(16), .OUT_BW(24), .NUM_IN(5), .SAT(0)) u_n5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .in_last(il[1]),
        .data_in_flat(din[1][79:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(os1), .out_ovf(oo[1]));
    // d=2: 20-bit wrap
    adder_tree_pipe #(.IN_BW(16), .OUT_BW(20), .NUM_IN(16), .SAT(0)) u_w20 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .in_last(il[2]),
        .data_in_flat(din[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(os2), .out_ovf(oo[2]));
    // d=3: 20-bit saturate
    adder_tree_pipe #(.IN_BW(16), .OUT_BW(20), .NUM_IN(16), .SAT(1)) u_s20 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(irdy[3]), .in_last(il[3]),
        .data_in_flat(din[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_sum(os3), .out_ovf(oo[3]));

    typedef struct {
        int d;
        int sum;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input bit ok, input int a, input int e);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    endtask

    function automatic logic [255:0] fill(input int n, input int v);
        logic [255:0] r;
        logic [15:0]  e;
        r = '0;
        e = v[15:0];
        for (int i = 0; i < n; i++) r[i*16 +: 16] = e;
        return r;
    endfunction

    // Present one beat on DUT d, wait (bounded) for acceptance. Caller is at #1 after a posedge.
    task automatic beat(input int d, input logic [255:0] v, input bit last,
                        input int esum, input bit eovf, output int acc_cyc);
        int n;
        n = 0;
        iv[d]  = 1'b1;
        din[d] = v;
        il[d]  = last;
        @(negedge clk);
        while (!irdy[d] && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!irdy[d]) chk("accept_timeout", 1'b0, 0, 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        iv[d]   = 1'b0;
        il[d]   = 1'b0;
        if (last) sb.push_back('{d: d, sum: esum, ovf: eovf});
    endtask

    // Wait (bounded) until out_valid of DUT d is seen at a negedge.
    task automatic wait_valid(input int d, output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!ov[d] && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("out_valid_seen", ov[d], int'(ov[d]), 1);
        c = cyc;
    endtask

    // Monitor: pop and compare whenever a DUT hands over a result.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 4; d++) begin
                if (ov[d] && ordy[d]) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected", 1'b0, act[d], 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_dut", e.d == d, d, e.d);
                        chk("sb_sum", act[d] == e.sum, act[d], e.sum);
                        chk("sb_ovf", oo[d] == e.ovf, int'(oo[d]), int'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
        int a, c, n;
        int e5 [5];
        logic [255:0] v;

        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            iv[d] = 1'b0; il[d] = 1'b0; ordy[d] = 1'b1; din[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("rst_out_valid", ov[d] == 1'b0, int'(ov[d]), 0);
            chk("rst_out_sum", act[d] == 0, act[d], 0);
            chk("rst_out_ovf", oo[d] == 1'b0, int'(oo[d]), 0);
            chk("rst_in_ready", irdy[d] == 1'b0, int'(irdy[d]), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single beat of 1s on the 16-input tree: 16, latency 5.
        beat(0, fill(16, 1), 1'b1, 16, 1'b0, a);
        wait_valid(0, c);
        chk("t1_latency", (c - a + 1) == 5, c - a + 1, 5);
        @(posedge clk); #1;

        // Odd tree: {1,2,3,4,-20} -> -10 with latency 4, then all -1 -> -5.
        e5 = '{1, 2, 3, 4, -20};
        v = '0;
        for (int i = 0; i < 5; i++) v[i*16 +: 16] = e5[i][15:0];
        beat(1, v, 1'b1, -10, 1'b0, a);
        wait_valid(1, c);
        chk("t2_latency", (c - a + 1) == 4, c - a + 1, 4);
        @(posedge clk); #1;
        beat(1, fill(5, -1), 1'b1, -5, 1'b0, a);
        repeat (6) @(posedge clk); #1;

        // 3-beat group then 1-beat group, streamed back-to-back: 96 then 112.
        beat(0, fill(16, 1), 1'b0, 0, 1'b0, a);
        beat(0, fill(16, 2), 1'b0, 0, 1'b0, a);
        beat(0, fill(16, 3), 1'b1, 96, 1'b0, a);
        beat(0, fill(16, 7), 1'b1, 112, 1'b0, a);
        wait_valid(0, c);
        chk("t3_first_sum", act[0] == 96, act[0], 96);
        @(negedge clk);
        chk("t3_back_to_back", ov[0] && act[0] == 112, act[0], 112);
        @(posedge clk); #1;

        // 20-bit overflow: wrap vs saturate, positive and negative, sticky clears next group.
        beat(2, fill(16, 32767), 1'b0, 0, 1'b0, a);
        beat(2, fill(16, 32767), 1'b1, -32, 1'b1, a);
        beat(2, fill(16, 1), 1'b1, 16, 1'b0, a);
        beat(2, fill(16, -32768), 1'b0, 0, 1'b0, a);
        beat(2, fill(16, -32768), 1'b1, 0, 1'b1, a);
        beat(3, fill(16, 32767), 1'b0, 0, 1'b0, a);
        beat(3, fill(16, 32767), 1'b1, 524287, 1'b1, a);
        beat(3, fill(16, 1), 1'b1, 16, 1'b0, a);
        beat(3, fill(16, -32768), 1'b0, 0, 1'b0, a);
        beat(3, fill(16, -32768), 1'b1, -524288, 1'b1, a);
        repeat (8) @(posedge clk); #1;

        // Downstream stall for 3 cycles: result held, input blocked, order preserved.
        ordy[0] = 1'b0;
        fork
            begin
                int b;
                for (int g = 1; g <= 5; g++) beat(0, fill(16, g), 1'b1, 16 * g, 1'b0, b);
            end
            begin
                int cs;
                wait_valid(0, cs);
                for (int s = 0; s < 3; s++) begin
                    chk("t5_sum_hold", act[0] == 16, act[0], 16);
                    chk("t5_in_ready_low", irdy[0] == 1'b0, int'(irdy[0]), 0);
                    if (s < 2) @(negedge clk);
                end
                @(posedge clk);
                #1 ordy[0] = 1'b1;
            end
        join
        repeat (12) @(posedge clk); #1;

        // Reset mid-group: partial sums in acc and in the tree must be discarded.
        beat(0, fill(16, 5), 1'b0, 0, 1'b0, a);
        beat(0, fill(16, 5), 1'b0, 0, 1'b0, a);
        repeat (7) @(posedge clk); #1;
        beat(0, fill(16, 5), 1'b0, 0, 1'b0, a);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_rst_out_valid", ov[0] == 1'b0, int'(ov[0]), 0);
        chk("t6_rst_out_sum", act[0] == 0, act[0], 0);
        chk("t6_rst_out_ovf", oo[0] == 1'b0, int'(oo[0]), 0);
        chk("t6_rst_in_ready", irdy[0] == 1'b0, int'(irdy[0]), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(0, fill(16, 2), 1'b1, 32, 1'b0, a);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("sb_drained", sb.size() == 0, sb.size(), 0);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
